reset_sequencer_tmr: RTL and testbench

//  Parametrised, self-voting reset generator for NCH redundant channels (NCH=3 for TMR) and NDOM reset domains.
//  - Merges global reset, per-channel power-on requests and a soft-reset pulse.
//  - Stretches the merged reset, then releases the domains in order, GAP cycles apart.
//  - Majority-votes its own state every cycle, so an upset in one channel is scrubbed.
//  - Sits at top level; drives every per-domain, per-channel reset line.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/tmr_voter.sv | 20 ++
 rtl/reset_sequencer_tmr.sv | 188 ++++++++++++++++++
 tb/tb_reset_sequencer_tmr.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the redundant reset sequencer: FSM state encoding and
// the bitwise majority function used by the channel voter.
package reset_seq_pkg;

    // Per-channel sequencer states.
    typedef logic [1:0] state_t;
    localparam state_t StAssert = 2'd0;
    localparam state_t StHold   = 2'd1;
    localparam state_t StSeq    = 2'd2;
    localparam state_t StRun    = 2'd3;

    // Widest vector maj3() can vote on; callers zero-extend and size-cast back.
    localparam int unsigned MajW = 64;

    // Bitwise 2-of-3 majority.
    function automatic logic [MajW-1:0] maj3(input logic [MajW-1:0] a,
                                             input logic [MajW-1:0] b,
                                             input logic [MajW-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_voter.sv
// Three-way bitwise majority voter with a disagreement flag.
module tmr_voter
    import reset_seq_pkg::*;
#(
    parameter int unsigned W = 8  // must not exceed MajW
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] voted_o,
    output logic         mismatch_o
);

    // Vote each bit, then flag any copy that differs from the result.
    always_comb begin
        voted_o    = W'(maj3(MajW'(a_i), MajW'(b_i), MajW'(c_i)));
        mismatch_o = (a_i != voted_o) | (b_i != voted_o) | (c_i != voted_o);
    end

endmodule

// File: rtl/reset_sequencer_tmr.sv
// Redundant reset generator: merges reset requests, stretches the merged reset,
// then releases NDOM domains in order. With NCH=3 the per-channel state is
// majority-voted every cycle so a single upset channel is overwritten.
module reset_sequencer_tmr
    import reset_seq_pkg::*;
#(
    parameter int unsigned NCH     = 3,
    parameter int unsigned NDOM    = 3,
    parameter int unsigned STRETCH = 16,
    parameter int unsigned GAP     = 4,
    parameter int unsigned ERRW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       por_req,
    input  logic                 soft_req,
    output logic [NCH*NDOM-1:0]  rst_o,
    output logic [NCH-1:0]       ready_o,
    output logic                 err_o,
    output logic [ERRW-1:0]      err_cnt_o
);

    localparam int unsigned IW = (NDOM > 1) ? $clog2(NDOM) : 1;
    localparam int unsigned HW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    // Packed channel state: {state, idx, hold_cnt, gap_cnt}.
    localparam int unsigned W  = 2 + IW + HW + GW;

    localparam logic [HW-1:0] HoldInit = HW'(STRETCH - 1);
    localparam logic [GW-1:0] GapInit  = GW'(GAP - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(NDOM - 1);
    localparam logic [W-1:0]  StInit   = {StAssert, {IW{1'b0}}, HoldInit, {GW{1'b0}}};

    logic [NCH*W-1:0] ch_all;
    logic [W-1:0]     voted;
    logic             st_mis;
    logic             por_mis;
    logic             req;

    state_t           cur_st;
    logic [IW-1:0]    cur_idx;
    logic [HW-1:0]    cur_hold;
    logic [GW-1:0]    cur_gap;

    state_t           nxt_st;
    logic [IW-1:0]    nxt_idx;
    logic [HW-1:0]    nxt_hold;
    logic [GW-1:0]    nxt_gap;
    logic [W-1:0]     nxt;
    logic [NDOM-1:0]  nxt_rst;
    logic             nxt_rdy;

    // Voting, request merge and error accounting depend on redundancy.
    if (NCH == 3) begin : g_tmr
        logic            err_q;
        logic [ERRW-1:0] err_cnt_q;

        tmr_voter #(
            .W (W)
        ) u_voter (
            .a_i        (ch_all[0 +: W]),
            .b_i        (ch_all[W +: W]),
            .c_i        (ch_all[2*W +: W]),
            .voted_o    (voted),
            .mismatch_o (st_mis)
        );

        assign req     = (por_req[0] & por_req[1]) | (por_req[0] & por_req[2]) |
                         (por_req[1] & por_req[2]) | soft_req;
        assign por_mis = (|por_req) & ~(&por_req);

        // Sticky flag and saturating count of disagreement cycles.
        always_ff @(posedge clk) begin
            if (rst) begin
                err_q     <= 1'b0;
                err_cnt_q <= '0;
            end else if (st_mis | por_mis) begin
                err_q <= 1'b1;
                if (err_cnt_q != {ERRW{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end
        end

        assign err_o     = err_q;
        assign err_cnt_o = err_cnt_q;
    end else begin : g_single
        assign voted     = ch_all[W-1:0];
        assign st_mis    = 1'b0;
        assign por_mis   = 1'b0;
        assign req       = por_req[0] | soft_req;
        assign err_o     = 1'b0;
        assign err_cnt_o = '0;
    end

    assign cur_st   = voted[W-1 -: 2];
    assign cur_idx  = voted[HW+GW +: IW];
    assign cur_hold = voted[GW +: HW];
    assign cur_gap  = voted[0 +: GW];

    // Next state from the voted state; any request restarts from ASSERT.
    always_comb begin
        nxt_st   = cur_st;
        nxt_idx  = cur_idx;
        nxt_hold = cur_hold;
        nxt_gap  = cur_gap;
        if (req) begin
            nxt_st   = StAssert;
            nxt_idx  = '0;
            nxt_hold = HoldInit;
            nxt_gap  = '0;
        end else begin
            case (cur_st)
                StAssert: begin
                    nxt_st   = StHold;
                    nxt_idx  = '0;
                    nxt_hold = HoldInit;
                    nxt_gap  = '0;
                end
                StHold: begin
                    if (cur_hold == '0) begin
                        nxt_st  = StSeq;
                        nxt_idx = '0;
                        nxt_gap = GapInit;
                    end else begin
                        nxt_hold = cur_hold - 1'b1;
                    end
                end
                StSeq: begin
                    if (cur_gap == '0) begin
                        if (cur_idx == IdxLast) begin
                            nxt_st = StRun;
                        end else begin
                            nxt_idx = cur_idx + 1'b1;
                            nxt_gap = GapInit;
                        end
                    end else begin
                        nxt_gap = cur_gap - 1'b1;
                    end
                end
                StRun: begin
                    nxt_st = StRun;
                end
                default: begin
                    nxt_st   = StAssert;
                    nxt_idx  = '0;
                    nxt_hold = HoldInit;
                    nxt_gap  = '0;
                end
            endcase
        end
    end

    assign nxt = {nxt_st, nxt_idx, nxt_hold, nxt_gap};

    // Decode outputs from the next state so the output registers line up with the state.
    always_comb begin
        nxt_rst = '1;
        for (int unsigned d = 0; d < NDOM; d++) begin
            nxt_rst[d] = !((nxt_st == StRun) || ((nxt_st == StSeq) && (IW'(d) <= nxt_idx)));
        end
        nxt_rdy = (nxt_st == StRun);
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [W-1:0]    ch_q;
        logic [NDOM-1:0] rst_q;
        logic            rdy_q;

        // Every channel reloads from the voted next state, scrubbing any upset copy.
        always_ff @(posedge clk) begin
            if (rst) begin
                ch_q  <= StInit;
                rst_q <= '1;
                rdy_q <= 1'b0;
            end else begin
                ch_q  <= nxt;
                rst_q <= nxt_rst;
                rdy_q <= nxt_rdy;
            end
        end

        assign ch_all[c*W +: W]        = ch_q;
        assign rst_o[c*NDOM +: NDOM]   = rst_q;
        assign ready_o[c]              = rdy_q;
    end

endmodule

// File: tb/tb_reset_sequencer_tmr.sv
// Directed bench for reset_sequencer_tmr (NCH=3, NDOM=3, STRETCH=4, GAP=2).
module tb_reset_sequencer_tmr;

    localparam int unsigned NCH     = 3;
    localparam int unsigned NDOM    = 3;
    localparam int unsigned STRETCH = 4;
    localparam int unsigned GAP     = 2;
    localparam int unsigned ERRW    = 8;

    // Channel layout for these parameters: {state[1:0], idx[1:0], hold[1:0], gap[0]}.
    localparam logic [6:0] RunVec    = 7'b11_10_00_0;
    localparam logic [6:0] UpsetVec  = 7'b00_10_00_0;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      por_req;
    logic                soft_req;
    logic [NCH*NDOM-1:0] rst_o;
    logic [NCH-1:0]      ready_o;
    logic                err_o;
    logic [ERRW-1:0]     err_cnt_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    reset_sequencer_tmr #(
        .NCH     (NCH),
        .NDOM    (NDOM),
        .STRETCH (STRETCH),
        .GAP     (GAP),
        .ERRW    (ERRW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .por_req   (por_req),
        .soft_req  (soft_req),
        .rst_o     (rst_o),
        .ready_o   (ready_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    // Expected resets, rel cycles after the first request-free cycle.
    function automatic logic [8:0] exp_rst(input int rel);
        logic [2:0] dom;
        for (int d = 0; d < 3; d++) begin
            dom[d] = !(rel >= int'(STRETCH) + 1 + d * int'(GAP));
        end
        return {dom, dom, dom};
    endfunction

    function automatic logic [2:0] exp_rdy(input int rel);
        return (rel >= int'(STRETCH) + 1 + int'(NDOM) * int'(GAP)) ? 3'b111 : 3'b000;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        por_req  = '0;
        soft_req = 1'b0;
        tick();
        checks++;
        if (rst_o !== 9'h1ff) begin
            errors++;
            $display("FAIL reset_rst_o: got %b want %b", rst_o, 9'h1ff);
        end
        checks++;
        if (ready_o !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 000", ready_o);
        end
        checks++;
        if (err_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_err: got err=%b cnt=%0d want 0/0", err_o, err_cnt_o);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_power_up;
        for (int k = 2; k <= 14; k++) begin
            checks++;
            if (rst_o !== exp_rst(k - 2) || ready_o !== exp_rdy(k - 2)) begin
                errors++;
                $display("FAIL power_up cyc %0d: got rst=%b rdy=%b want rst=%b rdy=%b",
                         cyc, rst_o, ready_o, exp_rst(k - 2), exp_rdy(k - 2));
            end
            tick();
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL power_up_err: got %b want 0", err_o);
        end
    endtask

    task automatic test_soft_pulse;
        while (cyc < 20) tick();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        for (int k = 21; k <= 33; k++) begin
            checks++;
            if (rst_o !== exp_rst(k - 21) || ready_o !== exp_rdy(k - 21)) begin
                errors++;
                $display("FAIL soft_pulse cyc %0d: got rst=%b rdy=%b want rst=%b rdy=%b",
                         cyc, rst_o, ready_o, exp_rst(k - 21), exp_rdy(k - 21));
            end
            tick();
        end
    endtask

    task automatic test_por_minority;
        por_req = 3'b001;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (rst_o !== 9'h000 || ready_o !== 3'b111) begin
                errors++;
                $display("FAIL por_minority step %0d: got rst=%b rdy=%b want 000000000/111",
                         k, rst_o, ready_o);
            end
        end
        por_req = 3'b000;
        checks++;
        if (err_o !== 1'b1 || err_cnt_o !== 8'd5) begin
            errors++;
            $display("FAIL por_minority_err: got err=%b cnt=%0d want 1/5", err_o, err_cnt_o);
        end
        tick();
        checks++;
        if (err_cnt_o !== 8'd5) begin
            errors++;
            $display("FAIL por_minority_hold: got cnt=%0d want 5", err_cnt_o);
        end
    endtask

    task automatic test_scrub;
        force dut.g_ch[1].ch_q = UpsetVec;
        #1;
        release dut.g_ch[1].ch_q;
        checks++;
        if (rst_o !== 9'h000 || ready_o !== 3'b111) begin
            errors++;
            $display("FAIL scrub_upset_cycle: got rst=%b rdy=%b want 000000000/111",
                     rst_o, ready_o);
        end
        tick();
        checks++;
        if (rst_o !== 9'h000 || ready_o !== 3'b111) begin
            errors++;
            $display("FAIL scrub_after: got rst=%b rdy=%b want 000000000/111", rst_o, ready_o);
        end
        checks++;
        if (dut.g_ch[1].ch_q !== RunVec) begin
            errors++;
            $display("FAIL scrub_revote: got %b want %b", dut.g_ch[1].ch_q, RunVec);
        end
        checks++;
        if (err_cnt_o !== 8'd6 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL scrub_err: got err=%b cnt=%0d want 1/6", err_o, err_cnt_o);
        end
        tick();
        checks++;
        if (err_cnt_o !== 8'd6) begin
            errors++;
            $display("FAIL scrub_err_hold: got cnt=%0d want 6", err_cnt_o);
        end
    endtask

    task automatic test_hold_por;
        int bad;
        bad = 0;
        por_req = 3'b111;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (rst_o !== 9'h1ff || ready_o !== 3'b000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_por_asserted: got %0d released cycles want 0", bad);
        end
        checks++;
        if (err_cnt_o !== 8'd6 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_por_err: got err=%b cnt=%0d want 1/6", err_o, err_cnt_o);
        end
        // Request and rst together behave as rst, which alone clears the error state.
        rst = 1'b1;
        tick();
        checks++;
        if (err_o !== 1'b0 || err_cnt_o !== 8'd0 || rst_o !== 9'h1ff) begin
            errors++;
            $display("FAIL hold_por_rst_clear: got err=%b cnt=%0d rst=%b want 0/0/111111111",
                     err_o, err_cnt_o, rst_o);
        end
        rst     = 1'b0;
        por_req = 3'b000;
    endtask

    task automatic test_mid_seq_soft;
        int base;
        base = cyc;
        rst  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        while (cyc - base < 10) tick();
        checks++;
        if (rst_o !== exp_rst(8)) begin
            errors++;
            $display("FAIL mid_seq_before: got %b want %b", rst_o, exp_rst(8));
        end
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        for (int k = 11; k <= 23; k++) begin
            checks++;
            if (rst_o !== exp_rst(k - 11) || ready_o !== exp_rdy(k - 11)) begin
                errors++;
                $display("FAIL mid_seq lc %0d: got rst=%b rdy=%b want rst=%b rdy=%b",
                         cyc - base, rst_o, ready_o, exp_rst(k - 11), exp_rdy(k - 11));
            end
            tick();
        end
        checks++;
        if (err_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL mid_seq_err: got err=%b cnt=%0d want 0/0", err_o, err_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_soft_pulse();
        test_por_minority();
        test_scrub();
        test_hold_por();
        test_mid_seq_soft();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
